riscv_core_icache_way_array: RTL and testbench

- Next-generation instruction-cache storage: N-way set-associative data, tag and valid arrays, with hit detection, tree-PLRU replacement, a refill FSM and fence.i flush.
- Returns one 32-bit instruction parcel per request, including parcels that straddle two cache lines (RVC 16-bit alignment).
- Sits between the fetch stage and the AXI read master.
- Owns its hit/miss decision, so no separate controller handshake is needed.

---
 rtl/riscv_core_icache_way_array.sv | 219 +++++++++++++++++++++
 tb/tb_riscv_core_icache_way_array.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_icache_way_array.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_icache_way_array
// Purpose  : N-way set-associative instruction cache storage with hit
//            detection, tree-PLRU replacement, line refill FSM and a
//            set-walking fence.i flush. Returns one 32-bit parcel per
//            request, including parcels that straddle two lines.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_icache_way_array #(
  parameter int NUM_WAYS           = 2,
  parameter int INDEX_WIDTH        = 7,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH         = 64,
  parameter int CORE_DATA_WIDTH    = 32,
  parameter int AXI_DATA_WIDTH     = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  input  logic [ADDR_WIDTH-1:0]      i_req_addr,
  output logic                       o_req_ready,
  output logic                       o_rsp_valid,
  output logic [CORE_DATA_WIDTH-1:0] o_rsp_data,
  input  logic                       i_flush,
  output logic                       o_flush_busy,
  output logic                       o_axi_req_valid,
  output logic [ADDR_WIDTH-1:0]      o_axi_req_addr,
  input  logic                       i_axi_req_ready,
  input  logic                       i_axi_rsp_valid,
  input  logic [AXI_DATA_WIDTH-1:0]  i_axi_rsp_data
);

  localparam int CACHE_DEPTH = 2**INDEX_WIDTH;
  localparam int OFF_W       = BLOCK_OFFSET_WIDTH + 2;
  localparam int TAG_W       = ADDR_WIDTH - INDEX_WIDTH - OFF_W;
  localparam int WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int HALF_W      = CORE_DATA_WIDTH / 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_MISS_REQ  = 3'd2;
  localparam logic [2:0] S_MISS_WAIT = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;

  localparam logic [ADDR_WIDTH-1:0]         c_two      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0]         c_half_msk = ~ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]         c_line_msk = ~ADDR_WIDTH'((2**OFF_W) - 1);
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] c_word_one = BLOCK_OFFSET_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0]        c_idx_one  = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0]        c_idx_last = '1;

  // Storage: data/tag are plain RAMs, valid/PLRU are resettable flops.
  logic [AXI_DATA_WIDTH-1:0] r_data  [NUM_WAYS][CACHE_DEPTH];
  logic [TAG_W-1:0]          r_tag   [NUM_WAYS][CACHE_DEPTH];
  logic [CACHE_DEPTH-1:0]    r_valid [NUM_WAYS];
  logic [2:0]                r_plru  [CACHE_DEPTH];

  logic [2:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  r_miss_addr;
  logic                   r_flush_pend;
  logic [INDEX_WIDTH-1:0] r_fcnt;

  logic [ADDR_WIDTH-1:0]         w_addr_b;
  logic [INDEX_WIDTH-1:0]        w_idx_a, w_idx_b, w_midx;
  logic [TAG_W-1:0]              w_tag_a, w_tag_b, w_mtag;
  logic [NUM_WAYS-1:0]           w_hv_a, w_hv_b;
  logic                          w_hit_a, w_hit_b, w_cross, w_all_hit;
  logic [WAY_W-1:0]              w_way_a, w_way_b, w_victim;
  logic [AXI_DATA_WIDTH-1:0]     w_line_a, w_line_b;
  logic [BLOCK_OFFSET_WIDTH-1:0] w_word_a, w_word_a_n;
  logic [CORE_DATA_WIDTH-1:0]    w_lo, w_hi, w_parcel;
  logic [2*CORE_DATA_WIDTH-1:0]  w_window;
  logic                          w_refill;

  // Tree-PLRU: bit0 is the root (0 = left pair is LRU), bit1/bit2 pick
  // within the left/right pair. Two-way uses bit0 only as the LRU way.
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    if (NUM_WAYS == 4) return b[0] ? (b[2] ? 2'd3 : 2'd2) : (b[1] ? 2'd1 : 2'd0);
    else if (NUM_WAYS == 2) return {1'b0, b[0]};
    else return 2'd0;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] n;
    n = b;
    if (NUM_WAYS == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end else if (NUM_WAYS == 2) begin
      n[0] = ~w[0];
    end
    return n;
  endfunction

  assign w_addr_b   = r_addr + c_two;
  assign w_idx_a    = r_addr[OFF_W +: INDEX_WIDTH];
  assign w_tag_a    = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_idx_b    = w_addr_b[OFF_W +: INDEX_WIDTH];
  assign w_tag_b    = w_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign w_midx     = r_miss_addr[OFF_W +: INDEX_WIDTH];
  assign w_mtag     = r_miss_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_cross    = &r_addr[OFF_W-1:1];
  assign w_word_a   = r_addr[2 +: BLOCK_OFFSET_WIDTH];
  assign w_word_a_n = w_word_a + c_word_one;
  assign w_refill   = (r_state == S_MISS_WAIT) && i_axi_rsp_valid;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    assign w_hv_a[g] = r_valid[g][w_idx_a] && (r_tag[g][w_idx_a] == w_tag_a);
    assign w_hv_b[g] = r_valid[g][w_idx_b] && (r_tag[g][w_idx_b] == w_tag_b);
  end

  // Hit way encode (lowest way wins) and parcel assembly from line A/B.
  always_comb begin
    w_way_a = '0;
    w_way_b = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (w_hv_a[w]) w_way_a = WAY_W'(w);
      if (w_hv_b[w]) w_way_b = WAY_W'(w);
    end
    w_hit_a   = |w_hv_a;
    w_hit_b   = |w_hv_b;
    w_all_hit = w_hit_a && (!w_cross || w_hit_b);
    w_line_a  = r_data[w_way_a][w_idx_a];
    w_line_b  = r_data[w_way_b][w_idx_b];
    w_lo      = w_line_a[CORE_DATA_WIDTH*int'(w_word_a) +: CORE_DATA_WIDTH];
    w_hi      = w_cross ? w_line_b[CORE_DATA_WIDTH-1:0]
                        : w_line_a[CORE_DATA_WIDTH*int'(w_word_a_n) +: CORE_DATA_WIDTH];
    w_window  = {w_hi, w_lo};
    w_parcel  = r_addr[1] ? w_window[HALF_W +: CORE_DATA_WIDTH] : w_window[CORE_DATA_WIDTH-1:0];
  end

  // Victim: lowest invalid way in the refill set, else the PLRU choice.
  always_comb begin
    w_victim = WAY_W'(plru_victim(r_plru[w_midx]));
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_midx]) w_victim = WAY_W'(w);
    end
  end

  assign o_req_ready     = (r_state == S_IDLE) && !r_flush_pend;
  assign o_rsp_valid     = (r_state == S_LOOKUP) && w_all_hit;
  assign o_rsp_data      = o_rsp_valid ? w_parcel : '0;
  assign o_flush_busy    = r_flush_pend || (r_state == S_FLUSH);
  assign o_axi_req_valid = (r_state == S_MISS_REQ);
  assign o_axi_req_addr  = r_miss_addr;

  // Control FSM: request acceptance, lookup, refill sequencing and flush walk.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_miss_addr  <= '0;
      r_flush_pend <= 1'b0;
      r_fcnt       <= '0;
    end else begin
      if (i_flush && (r_state != S_IDLE) && (r_state != S_FLUSH)) r_flush_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_flush || r_flush_pend) begin
            r_state      <= S_FLUSH;
            r_flush_pend <= 1'b0;
            r_fcnt       <= '0;
          end else if (i_req_valid) begin
            r_addr  <= i_req_addr & c_half_msk;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_all_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_miss_addr <= (w_hit_a ? w_addr_b : r_addr) & c_line_msk;
            r_state     <= S_MISS_REQ;
          end
        end
        S_MISS_REQ:  if (i_axi_req_ready) r_state <= S_MISS_WAIT;
        S_MISS_WAIT: if (i_axi_rsp_valid) r_state <= S_LOOKUP;
        S_FLUSH: begin
          r_fcnt <= r_fcnt + c_idx_one;
          if (r_fcnt == c_idx_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid and PLRU state: cleared by reset or flush walk, set by refill/hits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int w = 0; w < NUM_WAYS; w++) r_valid[w] <= '0;
      for (int s = 0; s < CACHE_DEPTH; s++) r_plru[s] <= '0;
    end else if (r_state == S_FLUSH) begin
      for (int w = 0; w < NUM_WAYS; w++) r_valid[w][r_fcnt] <= 1'b0;
      r_plru[r_fcnt] <= '0;
    end else begin
      if (w_refill) begin
        r_valid[w_victim][w_midx] <= 1'b1;
        r_plru[w_midx] <= plru_touch(r_plru[w_midx], 2'(w_victim));
      end
      if (o_rsp_valid) begin
        r_plru[w_idx_a] <= plru_touch(r_plru[w_idx_a], 2'(w_way_a));
        if (w_cross) r_plru[w_idx_b] <= plru_touch(r_plru[w_idx_b], 2'(w_way_b));
      end
    end
  end

  // Line and tag write into the victim way when refill data arrives.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_refill) begin
      r_data[w_victim][w_midx] <= i_axi_rsp_data;
      r_tag[w_victim][w_midx]  <= w_mtag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_icache_way_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_icache_way_array
// Purpose  : Directed self-checking bench for the instruction cache array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core_icache_way_array;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_req_valid;
  logic [63:0]  i_req_addr;
  logic         o_req_ready;
  logic         o_rsp_valid;
  logic [31:0]  o_rsp_data;
  logic         i_flush;
  logic         o_flush_busy;
  logic         o_axi_req_valid;
  logic [63:0]  o_axi_req_addr;
  logic         i_axi_req_ready;
  logic         i_axi_rsp_valid;
  logic [255:0] i_axi_rsp_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] d;
  logic [63:0] la;
  int          n, lat, cnt;
  bit          ok;

  always #5 i_clk = ~i_clk;

  riscv_core_icache_way_array dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req_valid     (i_req_valid),
    .i_req_addr      (i_req_addr),
    .o_req_ready     (o_req_ready),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_data      (o_rsp_data),
    .i_flush         (i_flush),
    .o_flush_busy    (o_flush_busy),
    .o_axi_req_valid (o_axi_req_valid),
    .o_axi_req_addr  (o_axi_req_addr),
    .i_axi_req_ready (i_axi_req_ready),
    .i_axi_rsp_valid (i_axi_rsp_valid),
    .i_axi_rsp_data  (i_axi_rsp_data)
  );

  // Backing memory contents, one pattern per line address.
  function automatic logic [255:0] mem_line(input logic [63:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) begin
      case (a)
        64'h1000: l[32*k +: 32] = 32'(32'h11111111 * k);
        64'h1020: l[32*k +: 32] = (k == 0) ? 32'hAAAAAAAA : 32'(32'hBBBB0000 + k);
        64'h2000: l[32*k +: 32] = 32'(32'h20000000 + k);
        64'h3000: l[32*k +: 32] = 32'(32'h30000000 + k);
        default:  l[32*k +: 32] = 32'(32'hDEAD0000 + k);
      endcase
    end
    return l;
  endfunction

  task automatic issue(input logic [63:0] a, output bit okay);
    int cyc = 0;
    while (!o_req_ready && cyc < 400) begin @(posedge i_clk); #1; cyc++; end
    okay = o_req_ready;
    if (!okay) return;
    i_req_valid = 1'b1; i_req_addr = a;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_axi(output bit okay);
    int cyc = 0;
    while (!o_axi_req_valid && cyc < 50) begin @(posedge i_clk); #1; cyc++; end
    okay = o_axi_req_valid;
  endtask

  // Full fetch with an always-ready memory; reports data, refill count,
  // first refill address and latency (0 = response the cycle after accept).
  task automatic fetch(input logic [63:0] a, output logic [31:0] data, output int nax,
                       output logic [63:0] la0, output int lt, output bit okay);
    int cyc;
    logic [63:0] ra;
    data = '0; nax = 0; la0 = '0; lt = -1;
    issue(a, okay);
    if (!okay) return;
    okay = 1'b0; cyc = 0;
    while (!okay && cyc < 200) begin
      if (o_rsp_valid) begin
        data = o_rsp_data; lt = cyc; okay = 1'b1;
      end else if (o_axi_req_valid) begin
        ra = o_axi_req_addr;
        if (nax == 0) la0 = ra;
        nax++;
        i_axi_req_ready = 1'b1; @(posedge i_clk); #1; i_axi_req_ready = 1'b0;
        i_axi_rsp_valid = 1'b1; i_axi_rsp_data = mem_line(ra);
        @(posedge i_clk); #1;
        i_axi_rsp_valid = 1'b0; i_axi_rsp_data = '0;
        cyc += 2;
      end else begin
        @(posedge i_clk); #1; cyc++;
      end
    end
    if (okay) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", o_rsp_valid); end
    total++; if (o_axi_req_valid !== 1'b0) begin bad++; $display("FAIL reset_axi_valid got %b want 0", o_axi_req_valid); end
    total++; if (o_flush_busy !== 1'b0) begin bad++; $display("FAIL reset_flush_busy got %b want 0", o_flush_busy); end
    total++; if (o_rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got %h want 0", o_rsp_data); end
    total++; if (o_axi_req_addr !== 64'h0) begin bad++; $display("FAIL reset_axi_addr got %h want 0", o_axi_req_addr); end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", o_req_ready); end
  endtask

  task automatic test_miss_refill;
    fetch(64'h1000, d, n, la, lat, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL miss_done got %b want 1", ok); end
    total++; if (n != 1) begin bad++; $display("FAIL miss_axi_count got %0d want 1", n); end
    total++; if (la !== 64'h1000) begin bad++; $display("FAIL miss_axi_addr got %h want 1000", la); end
    total++; if (d !== 32'h00000000) begin bad++; $display("FAIL miss_data got %h want 00000000", d); end
  endtask

  task automatic test_hit;
    fetch(64'h1004, d, n, la, lat, ok);
    total++; if (d !== 32'h11111111) begin bad++; $display("FAIL hit_data got %h want 11111111", d); end
    total++; if (lat != 0) begin bad++; $display("FAIL hit_latency got %0d want 0", lat); end
    total++; if (n != 0) begin bad++; $display("FAIL hit_axi_count got %0d want 0", n); end
    // Halfword-aligned parcel inside one line: {word1[15:0], word0[31:16]}.
    fetch(64'h1002, d, n, la, lat, ok);
    total++; if (d !== 32'h11110000) begin bad++; $display("FAIL hit_half_data got %h want 11110000", d); end
    fetch(64'h101C, d, n, la, lat, ok);
    total++; if (d !== 32'h77777777) begin bad++; $display("FAIL hit_last_word got %h want 77777777", d); end
  endtask

  task automatic test_crossing;
    fetch(64'h101E, d, n, la, lat, ok);
    total++; if (d !== 32'hAAAA7777) begin bad++; $display("FAIL cross_data got %h want AAAA7777", d); end
    total++; if (n != 1) begin bad++; $display("FAIL cross_axi_count got %0d want 1", n); end
    total++; if (la !== 64'h1020) begin bad++; $display("FAIL cross_axi_addr got %h want 1020", la); end
    // Bit 0 ignored; both lines now resident.
    fetch(64'h101F, d, n, la, lat, ok);
    total++; if (d !== 32'hAAAA7777 || n != 0) begin bad++; $display("FAIL cross_hit got %h/%0d want AAAA7777/0", d, n); end
    // Double miss: two refills, line A first.
    fetch(64'h503E, d, n, la, lat, ok);
    total++; if (n != 2) begin bad++; $display("FAIL cross2_axi_count got %0d want 2", n); end
    total++; if (la !== 64'h5020) begin bad++; $display("FAIL cross2_first_addr got %h want 5020", la); end
    total++; if (d !== 32'h0000DEAD) begin bad++; $display("FAIL cross2_data got %h want 0000DEAD", d); end
  endtask

  task automatic test_plru;
    fetch(64'h2000, d, n, la, lat, ok);
    total++; if (n != 1 || d !== 32'h20000000) begin bad++; $display("FAIL plru_fill2000 got %0d/%h want 1/20000000", n, d); end
    fetch(64'h1000, d, n, la, lat, ok);
    total++; if (n != 0) begin bad++; $display("FAIL plru_touch1000 got %0d want 0", n); end
    fetch(64'h3000, d, n, la, lat, ok);
    total++; if (n != 1 || d !== 32'h30000000) begin bad++; $display("FAIL plru_fill3000 got %0d/%h want 1/30000000", n, d); end
    fetch(64'h1000, d, n, la, lat, ok);
    total++; if (n != 0 || d !== 32'h0) begin bad++; $display("FAIL plru_keep1000 got %0d/%h want 0/0", n, d); end
    fetch(64'h2000, d, n, la, lat, ok);
    total++; if (n != 1) begin bad++; $display("FAIL plru_evict2000 got %0d want 1", n); end
  endtask

  task automatic test_flush_idle;
    // Flush and request together: flush wins, request dropped.
    i_flush = 1'b1; i_req_valid = 1'b1; i_req_addr = 64'h1000;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_req_valid = 1'b0;
    cnt = 0; ok = 1'b0;
    while (o_flush_busy && cnt < 300) begin
      if (o_rsp_valid || o_axi_req_valid) ok = 1'b1;
      cnt++;
      @(posedge i_clk); #1;
    end
    total++; if (cnt != 128) begin bad++; $display("FAIL flush_idle_cycles got %0d want 128", cnt); end
    total++; if (ok !== 1'b0) begin bad++; $display("FAIL flush_idle_req_dropped got %b want 0", ok); end
    fetch(64'h1004, d, n, la, lat, ok);
    total++; if (n != 1 || d !== 32'h11111111) begin bad++; $display("FAIL flush_idle_miss got %0d/%h want 1/11111111", n, d); end
  endtask

  task automatic test_flush_during_miss;
    issue(64'h6000, ok);
    wait_axi(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fmiss_axi_timeout got %b want 1", ok); end
    i_axi_req_ready = 1'b1; @(posedge i_clk); #1; i_axi_req_ready = 1'b0;
    i_flush = 1'b1; @(posedge i_clk); #1; i_flush = 1'b0;
    total++; if (o_flush_busy !== 1'b1) begin bad++; $display("FAIL fmiss_busy got %b want 1", o_flush_busy); end
    i_axi_rsp_valid = 1'b1; i_axi_rsp_data = mem_line(64'h6000);
    @(posedge i_clk); #1;
    i_axi_rsp_valid = 1'b0;
    total++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'hDEAD0000) begin bad++; $display("FAIL fmiss_rsp got %b/%h want 1/DEAD0000", o_rsp_valid, o_rsp_data); end
    // One IDLE cycle holding the pending flush, then 128 walk cycles.
    cnt = 0;
    @(posedge i_clk); #1;
    while (o_flush_busy && cnt < 300) begin cnt++; @(posedge i_clk); #1; end
    total++; if (cnt != 129) begin bad++; $display("FAIL fmiss_busy_cycles got %0d want 129", cnt); end
    fetch(64'h1000, d, n, la, lat, ok);
    total++; if (n != 1) begin bad++; $display("FAIL fmiss_after_miss got %0d want 1", n); end
  endtask

  task automatic test_axi_stall;
    issue(64'h7000, ok);
    wait_axi(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_axi_timeout got %b want 1", ok); end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (o_axi_req_valid !== 1'b1 || o_axi_req_addr !== 64'h7000 || o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cycle %0d got v=%b a=%h rdy=%b rsp=%b want 1/7000/0/0",
                 c, o_axi_req_valid, o_axi_req_addr, o_req_ready, o_rsp_valid);
      end
      @(posedge i_clk); #1;
    end
    i_axi_req_ready = 1'b1; @(posedge i_clk); #1; i_axi_req_ready = 1'b0;
    i_axi_rsp_valid = 1'b1; i_axi_rsp_data = mem_line(64'h7000);
    @(posedge i_clk); #1;
    i_axi_rsp_valid = 1'b0;
    total++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'hDEAD0000) begin bad++; $display("FAIL stall_rsp got %b/%h want 1/DEAD0000", o_rsp_valid, o_rsp_data); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset_midrefill;
    issue(64'h8000, ok);
    wait_axi(ok);
    i_axi_req_ready = 1'b1; @(posedge i_clk); #1; i_axi_req_ready = 1'b0;
    i_rst = 1'b1; @(posedge i_clk); #1; i_rst = 1'b0;
    total++; if (o_req_ready !== 1'b1 || o_axi_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_state got rdy=%b v=%b want 1/0", o_req_ready, o_axi_req_valid); end
    i_axi_rsp_valid = 1'b1; i_axi_rsp_data = {8{32'h99999999}};
    @(posedge i_clk); #1;
    i_axi_rsp_valid = 1'b0; i_axi_rsp_data = '0;
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got %b want 0", o_rsp_valid); end
    fetch(64'h8000, d, n, la, lat, ok);
    total++; if (n != 1 || d !== 32'hDEAD0000) begin bad++; $display("FAIL rstmid_miss got %0d/%h want 1/DEAD0000", n, d); end
  endtask

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_flush = 1'b0;
    i_axi_req_ready = 1'b0; i_axi_rsp_valid = 1'b0; i_axi_rsp_data = '0;
    test_reset();
    test_miss_refill();
    test_hit();
    test_crossing();
    test_plru();
    test_flush_idle();
    test_flush_during_miss();
    test_axi_stall();
    test_reset_midrefill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
